// File: rtl/udma_uart_tx_engine.sv
// uDMA UART transmit engine: TX word FIFO feeding a serialiser with a run-time frame format.
// The frame format is captured at frame start so mid-frame config changes cannot corrupt a frame.
module udma_uart_tx_engine #(
    parameter int FIFO_DEPTH = 4,
    parameter int DIV_W      = 16
) (
    input  logic                          sys_clk_i,
    input  logic                          rst_i,
    input  logic                          cfg_en_i,
    input  logic [DIV_W-1:0]              cfg_div_i,
    input  logic [1:0]                    cfg_bits_i,
    input  logic                          cfg_parity_en_i,
    input  logic                          cfg_parity_odd_i,
    input  logic                          cfg_stop2_i,
    input  logic [7:0]                    data_tx_i,
    input  logic                          data_tx_valid_i,
    output logic                          data_tx_ready_o,
    output logic                          uart_tx_o,
    output logic                          uart_tx_oe_o,
    output logic                          busy_o,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level_o,
    output logic                          tx_done_evt_o
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;

    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

    typedef struct packed {
        logic [DIV_W-1:0] div;
        logic [2:0]       last_bit;
        logic             par_en;
        logic             stop2;
    } frame_cfg_t;

    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [LW-1:0] level;
    logic          push, pop;
    logic [7:0]    head, head_mask;

    assign data_tx_ready_o = (level != LW'(FIFO_DEPTH));
    assign push            = data_tx_valid_i && data_tx_ready_o;
    assign head            = mem[rd_ptr];
    assign head_mask       = 8'hFF >> (2'd3 - cfg_bits_i);
    assign fifo_level_o    = level;

    always_ff @(posedge sys_clk_i) begin
        if (push) mem[wr_ptr] <= data_tx_i;
    end

    always_ff @(posedge sys_clk_i) begin
        if (rst_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   level <= level + LW'(1);
                2'b01:   level <= level - LW'(1);
                default: level <= level;
            endcase
        end
    end

    state_t           state, state_n;
    logic [DIV_W-1:0] cnt, cnt_n;
    logic [2:0]       bit_idx, bit_n;
    logic             stop_sec, stop_n;
    logic [7:0]       shreg, sh_n;
    frame_cfg_t       cfg_q, cfg_n;
    logic             par_q, par_n;
    logic             tx_q, tx_n, busy_q, busy_n, done_q, done_n, oe_q;
    logic             start_ok, bit_end, launch;

    assign start_ok = cfg_en_i && (level != '0);
    assign bit_end  = (cnt == '0);

    always_comb begin
        state_n = state;
        cnt_n   = bit_end ? cfg_q.div : cnt - DIV_W'(1);
        bit_n   = bit_idx;
        stop_n  = stop_sec;
        sh_n    = shreg;
        cfg_n   = cfg_q;
        par_n   = par_q;
        tx_n    = tx_q;
        busy_n  = busy_q;
        launch  = 1'b0;
        pop     = 1'b0;

        case (state)
            S_IDLE: begin
                cnt_n  = cnt;
                launch = start_ok;
            end
            S_START: if (bit_end) begin
                state_n = S_DATA;
                tx_n    = shreg[0];
                sh_n    = shreg >> 1;
                bit_n   = '0;
            end
            S_DATA: if (bit_end) begin
                if (bit_idx == cfg_q.last_bit) begin
                    state_n = cfg_q.par_en ? S_PARITY : S_STOP;
                    tx_n    = cfg_q.par_en ? par_q : 1'b1;
                    stop_n  = 1'b0;
                end else begin
                    tx_n  = shreg[0];
                    sh_n  = shreg >> 1;
                    bit_n = bit_idx + 3'd1;
                end
            end
            S_PARITY: if (bit_end) begin
                state_n = S_STOP;
                tx_n    = 1'b1;
                stop_n  = 1'b0;
            end
            S_STOP: if (bit_end) begin
                if (cfg_q.stop2 && !stop_sec) begin
                    stop_n = 1'b1;
                end else if (start_ok) begin
                    launch = 1'b1;
                end else begin
                    state_n = S_IDLE;
                    tx_n    = 1'b1;
                    busy_n  = 1'b0;
                end
            end
            default: state_n = S_IDLE;
        endcase

        // Frame start: pop the head word and capture the whole frame format.
        if (launch) begin
            pop            = 1'b1;
            state_n        = S_START;
            tx_n           = 1'b0;
            busy_n         = 1'b1;
            cnt_n          = cfg_div_i;
            sh_n           = head;
            par_n          = (^(head & head_mask)) ^ cfg_parity_odd_i;
            cfg_n.div      = cfg_div_i;
            cfg_n.last_bit = 3'd4 + 3'(cfg_bits_i);
            cfg_n.par_en   = cfg_parity_en_i;
            cfg_n.stop2    = cfg_stop2_i;
        end

        // Registered pulse: asserted for the final clock of the last stop bit.
        done_n = (state_n == S_STOP) && (cnt_n == '0) && (!cfg_n.stop2 || stop_n);
    end

    always_ff @(posedge sys_clk_i) begin
        if (rst_i) begin
            state    <= S_IDLE;
            cnt      <= '0;
            bit_idx  <= '0;
            stop_sec <= 1'b0;
            shreg    <= '0;
            cfg_q    <= '0;
            par_q    <= 1'b0;
            tx_q     <= 1'b1;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            oe_q     <= 1'b0;
        end else begin
            state    <= state_n;
            cnt      <= cnt_n;
            bit_idx  <= bit_n;
            stop_sec <= stop_n;
            shreg    <= sh_n;
            cfg_q    <= cfg_n;
            par_q    <= par_n;
            tx_q     <= tx_n;
            busy_q   <= busy_n;
            done_q   <= done_n;
            oe_q     <= cfg_en_i || busy_q;
        end
    end

    assign uart_tx_o     = tx_q;
    assign busy_o        = busy_q;
    assign tx_done_evt_o = done_q;
    assign uart_tx_oe_o  = oe_q;

endmodule

// File: tb/tb_udma_uart_tx_engine.sv
// Directed bench for udma_uart_tx_engine: expected frames (line level per bit period) are queued
// by the stimulus and checked by a line monitor as the DUT emits them.
module tb_udma_uart_tx_engine;
    logic        sys_clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        cfg_en_i = 1'b0;
    logic [15:0] cfg_div_i = '0;
    logic [1:0]  cfg_bits_i = 2'd3;
    logic        cfg_parity_en_i = 1'b0;
    logic        cfg_parity_odd_i = 1'b0;
    logic        cfg_stop2_i = 1'b0;
    logic [7:0]  data_tx_i = '0;
    logic        data_tx_valid_i = 1'b0;
    logic        data_tx_ready_o;
    logic        uart_tx_o;
    logic        uart_tx_oe_o;
    logic        busy_o;
    logic [2:0]  fifo_level_o;
    logic        tx_done_evt_o;

    udma_uart_tx_engine #(.FIFO_DEPTH(4), .DIV_W(16)) dut (
        .sys_clk_i        (sys_clk_i),
        .rst_i            (rst_i),
        .cfg_en_i         (cfg_en_i),
        .cfg_div_i        (cfg_div_i),
        .cfg_bits_i       (cfg_bits_i),
        .cfg_parity_en_i  (cfg_parity_en_i),
        .cfg_parity_odd_i (cfg_parity_odd_i),
        .cfg_stop2_i      (cfg_stop2_i),
        .data_tx_i        (data_tx_i),
        .data_tx_valid_i  (data_tx_valid_i),
        .data_tx_ready_o  (data_tx_ready_o),
        .uart_tx_o        (uart_tx_o),
        .uart_tx_oe_o     (uart_tx_oe_o),
        .busy_o           (busy_o),
        .fifo_level_o     (fifo_level_o),
        .tx_done_evt_o    (tx_done_evt_o)
    );

    always #5 sys_clk_i = ~sys_clk_i;

    typedef struct {
        logic [15:0] line;
        int          nbits;
        int          div;
        bit          b2b;
    } frame_t;

    frame_t sq[$];
    int     tests = 0;
    int     fails = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic expect_frame(input logic [15:0] line, input int nbits, input int div, input bit b2b);
        frame_t f;
        f.line = line; f.nbits = nbits; f.div = div; f.b2b = b2b;
        sq.push_back(f);
    endtask

    // Monitor: samples at negedge, compares each frame against the queue head.
    frame_t      cur;
    bit          mon_busy = 1'b0;
    int          k, errs, fidx = 0, ncyc = 0, last_end = -10;
    bit          done_ok;
    logic [15:0] got;

    always @(negedge sys_clk_i) begin
        if (rst_i) begin
            mon_busy = 1'b0;
        end else if (!mon_busy) begin
            if (tx_done_evt_o) begin
                tests++; fails++;
                $display("FAIL spurious_done: got 1 expected 0 at cycle %0d", ncyc);
            end
            if (uart_tx_o == 1'b0) begin
                if (sq.size() == 0) begin
                    tests++; fails++;
                    $display("FAIL unexpected_frame: got start bit expected idle at cycle %0d", ncyc);
                end else begin
                    cur = sq.pop_front();
                    mon_busy = 1'b1; k = 0; errs = 0; done_ok = 1'b1; got = '0;
                    if (cur.b2b) check("b2b_gap", ncyc - last_end, 1);
                end
            end
        end
        if (mon_busy) begin
            if (uart_tx_o !== cur.line[k / (cur.div + 1)]) errs++;
            if (busy_o !== 1'b1) errs++;
            if ((k % (cur.div + 1)) == cur.div) got[k / (cur.div + 1)] = uart_tx_o;
            if (tx_done_evt_o !== (k == cur.nbits * (cur.div + 1) - 1)) done_ok = 1'b0;
            if (k == cur.nbits * (cur.div + 1) - 1) begin
                tests++;
                if (errs != 0) begin
                    fails++;
                    $display("FAIL frame%0d: got line %h (%0d bad samples) expected %h", fidx, got, errs, cur.line);
                end
                check("done_pos", done_ok, 1);
                fidx++;
                mon_busy = 1'b0;
                last_end = ncyc;
            end
            k++;
        end
        ncyc++;
    end

    // All stimulus is applied 1 time unit after a rising edge.
    task automatic push_word(input logic [7:0] d);
        int n = 0;
        data_tx_i = d;
        data_tx_valid_i = 1'b1;
        while (!data_tx_ready_o && n < 2000) begin
            @(posedge sys_clk_i); #1; n++;
        end
        if (n >= 2000) begin
            tests++; fails++;
            $display("FAIL push_timeout: got ready 0 expected 1 for word %h", d);
        end
        @(posedge sys_clk_i); #1;
        data_tx_valid_i = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while ((sq.size() != 0 || mon_busy || busy_o) && n < 3000) begin
            @(posedge sys_clk_i); #1; n++;
        end
        if (n >= 3000) begin
            tests++; fails++;
            $display("FAIL drain_timeout: got %0d frames pending expected 0", sq.size());
        end
        repeat (2) @(posedge sys_clk_i);
        #1;
    endtask

    task automatic set_fmt(input int div, input int bits, input bit pen, input bit podd, input bit s2);
        cfg_div_i = 16'(div); cfg_bits_i = 2'(bits);
        cfg_parity_en_i = pen; cfg_parity_odd_i = podd; cfg_stop2_i = s2;
    endtask

    initial begin
        bit low_seen;
        repeat (3) @(posedge sys_clk_i);
        #1;
        check("rst_tx", uart_tx_o, 1);
        check("rst_oe", uart_tx_oe_o, 0);
        check("rst_busy", busy_o, 0);
        check("rst_done", tx_done_evt_o, 0);
        check("rst_level", fifo_level_o, 0);
        check("rst_ready", data_tx_ready_o, 1);
        rst_i = 1'b0;
        @(posedge sys_clk_i); #1;

        // 8N1, div=3, 0x55
        set_fmt(3, 3, 0, 0, 0);
        cfg_en_i = 1'b1;
        @(posedge sys_clk_i); #1;
        check("oe_on", uart_tx_oe_o, 1);
        expect_frame(16'h02AA, 10, 3, 0);
        push_word(8'h55);
        drain();
        check("busy_idle", busy_o, 0);

        // 7 data bits, odd parity, 2 stop, div=0, 0x41
        set_fmt(0, 2, 1, 1, 1);
        expect_frame(16'h0782, 11, 0, 0);
        push_word(8'h41);
        drain();

        // Fill with engine disabled, then four back-to-back frames
        cfg_en_i = 1'b0;
        set_fmt(1, 3, 0, 0, 0);
        expect_frame(16'h034A, 10, 1, 0);
        expect_frame(16'h0278, 10, 1, 1);
        expect_frame(16'h021E, 10, 1, 1);
        expect_frame(16'h03E0, 10, 1, 1);
        push_word(8'hA5); push_word(8'h3C); push_word(8'h0F); push_word(8'hF0);
        check("full_ready", data_tx_ready_o, 0);
        check("full_level", fifo_level_o, 4);
        data_tx_i = 8'h99; data_tx_valid_i = 1'b1;
        repeat (2) @(posedge sys_clk_i);
        #1;
        check("full_no_push", fifo_level_o, 4);
        data_tx_valid_i = 1'b0;
        cfg_en_i = 1'b1;
        drain();

        // Word length change mid-frame affects only the next frame
        cfg_en_i = 1'b0;
        expect_frame(16'h0386, 10, 1, 0);
        expect_frame(16'h0046, 7, 1, 1);
        push_word(8'hC3); push_word(8'hC3);
        cfg_en_i = 1'b1;
        repeat (6) @(posedge sys_clk_i);
        #1;
        cfg_bits_i = 2'd0;
        drain();
        cfg_bits_i = 2'd3;

        // Push coincident with popping the only entry
        cfg_en_i = 1'b0;
        set_fmt(0, 3, 0, 0, 0);
        expect_frame(16'h0302, 10, 0, 0);
        expect_frame(16'h02FC, 10, 0, 1);
        push_word(8'h81);
        cfg_en_i = 1'b1;
        push_word(8'h7E);
        check("level_pushpop_1", fifo_level_o, 1);
        drain();

        // Writer stalled on a full FIFO while frames drain it
        cfg_en_i = 1'b0;
        expect_frame(16'h0222, 10, 0, 0);
        expect_frame(16'h0244, 10, 0, 1);
        expect_frame(16'h0266, 10, 0, 1);
        expect_frame(16'h0288, 10, 0, 1);
        expect_frame(16'h02B4, 10, 0, 1);
        push_word(8'h11); push_word(8'h22); push_word(8'h33); push_word(8'h44);
        cfg_en_i = 1'b1;
        push_word(8'h5A);
        check("level_refill", fifo_level_o, 4);
        drain();

        // Reset during the data bits aborts the frame and flushes the FIFO
        set_fmt(3, 3, 0, 0, 0);
        expect_frame(16'h03FE, 10, 3, 0);
        push_word(8'hFF);
        push_word(8'h00);
        repeat (10) @(posedge sys_clk_i);
        #1;
        check("mid_busy", busy_o, 1);
        rst_i = 1'b1;
        @(posedge sys_clk_i); #1;
        rst_i = 1'b0;
        check("abort_tx", uart_tx_o, 1);
        check("abort_busy", busy_o, 0);
        check("abort_level", fifo_level_o, 0);
        check("abort_done", tx_done_evt_o, 0);
        check("abort_ready", data_tx_ready_o, 1);
        low_seen = 1'b0;
        repeat (20) begin
            @(posedge sys_clk_i); #1;
            if (uart_tx_o !== 1'b1) low_seen = 1'b1;
        end
        check("abort_line_idle", low_seen, 0);
        check("queue_empty", sq.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got still running expected finished");
        $fatal(1, "timeout");
    end
endmodule
